fb_loader: RTL and testbench

FB_LOADER -- requirements
Module: fb_loader

---
 rtl/fb_loader.sv | 155 +++++++++++++++
 tb/tb_fb_loader.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_loader.sv
// fb_loader: turns a UART byte stream (HEADER + NPIX/2 payload bytes) into 4-bit frame-buffer writes.
// Optional FB_LOADER_CHECKSUM_EN: a trailing XOR checksum byte decides between frame_done and frame_err.
module fb_loader #(
  parameter logic [7:0] HEADER  = 8'hA5,
  parameter int         NPIX    = 4096,
  parameter int         TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        fb_we,
  output logic [12:0] fb_addr,
  output logic [3:0]  fb_din,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_err
);

  localparam int              TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // The counter restarts at 0 on the edge that takes a byte, so firing at TIMEOUT-2
  // puts frame_err exactly TIMEOUT cycles after that byte's strobe.
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 2);
  localparam logic [12:0]     LAST_PIX = 13'(NPIX - 1);
  localparam logic [12:0]     LAST_HI  = 13'(NPIX - 2);

`ifdef FB_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, PAYLOAD} state_t;
`endif

  state_t         state;
  logic           pend_lo;
  logic [3:0]     lo_nib;
  logic [12:0]    pix;
  logic [TW-1:0]  tmo;
  logic           room;
  logic           finishing;

`ifdef FB_LOADER_CHECKSUM_EN
  logic [7:0]     csum;
  assign room      = 1'b1;
  assign finishing = 1'b0;
`else
  logic           full;
  logic           done_pend;
  assign room      = !full;
  assign finishing = done_pend;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    // NOTE: pulse outputs default low here; a later non-blocking assignment in the
    // same pass overrides the default, so each pulse lasts exactly one clock.
    fb_we      <= 1'b0;
    frame_done <= 1'b0;
    frame_err  <= 1'b0;
`ifndef FB_LOADER_CHECKSUM_EN
    done_pend  <= 1'b0;
`endif
    if (rst) begin
      state   <= IDLE;
      pend_lo <= 1'b0;
      lo_nib  <= '0;
      pix     <= '0;
      tmo     <= '0;
      fb_addr <= '0;
      fb_din  <= '0;
`ifdef FB_LOADER_CHECKSUM_EN
      csum    <= '0;
`else
      full    <= 1'b0;
`endif
    end else begin
      // Second nibble of the previous byte always completes, even on an abort.
      if (pend_lo) begin
        fb_we   <= 1'b1;
        fb_addr <= pix;
        fb_din  <= lo_nib;
        pend_lo <= 1'b0;
        if (pix != LAST_PIX) pix <= pix + 13'd1;
`ifndef FB_LOADER_CHECKSUM_EN
        done_pend <= full && !rx_ready;
`endif
      end

      case (state)
        IDLE: begin
          if (rx_ready && rx_data == HEADER) begin
            state <= PAYLOAD;
            pix   <= '0;
            tmo   <= '0;
`ifdef FB_LOADER_CHECKSUM_EN
            csum  <= '0;
`else
            full  <= 1'b0;
`endif
          end
        end

        PAYLOAD: begin
          if (finishing) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end else if (rx_ready && pend_lo) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else if (rx_ready && room) begin
            fb_we   <= 1'b1;
            fb_addr <= pix;
            fb_din  <= rx_data[7:4];
            lo_nib  <= rx_data[3:0];
            pend_lo <= 1'b1;
            pix     <= pix + 13'd1;
            tmo     <= '0;
`ifdef FB_LOADER_CHECKSUM_EN
            csum    <= csum ^ rx_data;
            if (pix == LAST_HI) state <= CHECK;
`else
            full    <= (pix == LAST_HI);
`endif
          end else if (tmo == TMO_LAST) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end

`ifdef FB_LOADER_CHECKSUM_EN
        CHECK: begin
          if (rx_ready && pend_lo) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else if (rx_ready) begin
            if (rx_data == csum) frame_done <= 1'b1;
            else                 frame_err  <= 1'b1;
            state <= IDLE;
          end else if (tmo == TMO_LAST) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_loader.sv
// Self-checking bench for fb_loader: a cycle-indexed scoreboard built from the frame rules,
// compared against the DUT every cycle, plus hand-computed literal checks per scenario.
module tb_fb_loader;

  localparam logic [7:0] HDR  = 8'hA5;
  localparam int         NPIX = 64;
  localparam int         NB   = NPIX / 2;
  localparam int         TMO  = 500;
  localparam int         MAXC = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_ready = 1'b0;
  logic        fb_we;
  logic [12:0] fb_addr;
  logic [3:0]  fb_din;
  logic        busy;
  logic        frame_done;
  logic        frame_err;

  fb_loader #(.HEADER(HDR), .NPIX(NPIX), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_din(fb_din),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Expected outputs per absolute cycle index
  bit          e_we[MAXC];
  bit          e_busy[MAXC];
  bit          e_done[MAXC];
  bit          e_err[MAXC];
  logic [12:0] e_addr[MAXC];
  logic [3:0]  e_din[MAXC];

  // Frame-level model state
  bit          m_act = 1'b0;
  bit          m_full = 1'b0;
  int          m_k = 0;
  int          m_last = -10;
  int          m_start = 0;
  int          m_end = 0;
  logic [7:0]  m_csum = '0;

  // Move the end of the current frame to cycle e; busy covers (start, e).
  task automatic set_end(int e, bit is_err);
    int hi;
    hi = (e > m_end) ? e : m_end;
    if (m_end > 0) begin
      e_done[m_end] = 1'b0;
      e_err[m_end]  = 1'b0;
    end
    for (int c = m_start + 1; c < hi; c++) e_busy[c] = (c < e);
    e_busy[e] = 1'b0;
    if (is_err) e_err[e] = 1'b1;
    else        e_done[e] = 1'b1;
    m_end = e;
  endtask

  task automatic model_strobe(int n, logic [7:0] d);
    if (m_act && n >= m_end) m_act = 1'b0;
    if (!m_act) begin
      if (d == HDR) begin
        m_act = 1'b1; m_full = 1'b0; m_k = 0; m_csum = '0;
        m_last = -10; m_start = n; m_end = 0;
        set_end(n + TMO, 1'b1);
      end
      return;
    end
    if (n == m_last + 1) begin
      set_end(n + 1, 1'b1);
      m_act = 1'b0;
      return;
    end
    if (m_full) begin
`ifdef FB_LOADER_CHECKSUM_EN
      set_end(n + 1, d != m_csum);
      m_act = 1'b0;
`endif
      return;
    end
    e_we[n+1] = 1'b1; e_addr[n+1] = 13'(2 * m_k);     e_din[n+1] = d[7:4];
    e_we[n+2] = 1'b1; e_addr[n+2] = 13'(2 * m_k + 1); e_din[n+2] = d[3:0];
    m_k++;
    m_csum ^= d;
    m_last = n;
    if (m_k == NB) m_full = 1'b1;
`ifndef FB_LOADER_CHECKSUM_EN
    if (m_full) begin
      set_end(n + 3, 1'b0);
      return;
    end
`endif
    set_end(n + TMO, 1'b1);
  endtask

  // rst high during cycle r: nothing scheduled after it may happen.
  task automatic model_reset(int r);
    int hi;
    hi = (m_end > r + 4) ? m_end : r + 4;
    for (int c = r + 1; c <= hi && c < MAXC; c++) begin
      e_we[c] = 1'b0; e_busy[c] = 1'b0; e_done[c] = 1'b0; e_err[c] = 1'b0;
    end
    m_act = 1'b0;
    m_end = 0;
  endtask

  // Observed frame-buffer contents and event counts
  logic [3:0] fbmem[NPIX];
  bit         fbwr[NPIX];
  int         n_wr = 0;
  int         n_done = 0;
  int         n_err = 0;
  int         err_cyc = -1;

  always @(negedge clk) begin
    if (chk_en && cyc < MAXC) begin
      check("busy", 32'(busy), 32'(e_busy[cyc]));
      check("frame_done", 32'(frame_done), 32'(e_done[cyc]));
      check("frame_err", 32'(frame_err), 32'(e_err[cyc]));
      check("fb_we", 32'(fb_we), 32'(e_we[cyc]));
      if (e_we[cyc]) begin
        check("fb_addr", 32'(fb_addr), 32'(e_addr[cyc]));
        check("fb_din", 32'(fb_din), 32'(e_din[cyc]));
      end
      if (fb_we === 1'b1 && fb_addr < NPIX) begin
        fbmem[fb_addr] = fb_din;
        fbwr[fb_addr]  = 1'b1;
        n_wr++;
      end
      if (frame_done === 1'b1) n_done++;
      if (frame_err === 1'b1) begin
        n_err++;
        err_cyc = cyc;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Strobe d in the current cycle, then leave gap-1 idle cycles.
  task automatic send(logic [7:0] d, int gap);
    rx_ready = 1'b1;
    rx_data  = d;
    model_strobe(cyc, d);
    tick(1);
    rx_ready = 1'b0;
    if (gap > 1) tick(gap - 1);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < NPIX; i++) begin
      fbmem[i] = 'x;
      fbwr[i]  = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0, e0, d0, last;
    clear_mem();
    // Header offered while reset is held must not start a frame.
    rst = 1'b1; rx_ready = 1'b1; rx_data = HDR;
    repeat (3) @(posedge clk);
    #1;
    rx_ready = 1'b0;
    check("rst_fb_we", 32'(fb_we), 32'd0);
    check("rst_fb_addr", 32'(fb_addr), 32'd0);
    check("rst_fb_din", 32'(fb_din), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    tick(2);

    // Non-header bytes in IDLE are ignored.
    send(8'h12, 3);
    send(8'h34, 3);
    tick(3);
    check("idle_no_write", 32'(n_wr), 32'd0);

    // Full frame of 0x3C, 100 cycles apart.
    clear_mem();
    send(HDR, 2);
    for (int i = 0; i < NB; i++) send(8'h3C, 100);
`ifdef FB_LOADER_CHECKSUM_EN
    send(m_csum, 3);
`endif
    tick(5);
    check("frame_writes", 32'(n_wr), 32'd64);
    check("frame_done_cnt", 32'(n_done), 32'd1);
    check("pix0", 32'(fbmem[0]), 32'h3);
    check("pix1", 32'(fbmem[1]), 32'hC);
    check("pix_last", 32'(fbmem[NPIX-1]), 32'hC);

    // Varied bytes, tight spacing, HEADER value inside the payload.
    clear_mem();
    send(HDR, 2);
    for (int i = 0; i < NB; i++) send((i == 3) ? HDR : 8'(i * 17 + 1), (i % 2 == 1) ? 2 : 3);
`ifdef FB_LOADER_CHECKSUM_EN
    send(m_csum, 3);
`endif
    tick(5);
    check("hdr_as_data_hi", 32'(fbmem[6]), 32'hA);
    check("hdr_as_data_lo", 32'(fbmem[7]), 32'h5);
    check("byte0_lo", 32'(fbmem[1]), 32'h1);
    check("frame2_done_cnt", 32'(n_done), 32'd2);

    // Timeout after 10 bytes.
    clear_mem();
    w0 = n_wr; e0 = n_err; last = 0;
    send(HDR, 2);
    for (int i = 0; i < 10; i++) begin
      if (i == 9) last = cyc;
      send(8'(8'h50 + i), 4);
    end
    tick(TMO + 10);
    check("tmo_writes", 32'(n_wr - w0), 32'd20);
    check("tmo_err_cnt", 32'(n_err - e0), 32'd1);
    check("tmo_latency", 32'(err_cyc - last), 32'(TMO));

    // Two strobes back to back mid-frame.
    clear_mem();
    w0 = n_wr; e0 = n_err; d0 = n_done;
    send(HDR, 2);
    send(8'h11, 3);
    send(8'h22, 3);
    send(8'h33, 3);
    send(8'h77, 1);
    send(8'h88, 3);
    tick(5);
    check("ovl_err_cnt", 32'(n_err - e0), 32'd1);
    check("ovl_writes", 32'(n_wr - w0), 32'd8);
    check("ovl_lo_done", 32'(fbmem[7]), 32'h7);
    check("ovl_dropped", 32'(fbwr[8]), 32'd0);
    check("ovl_no_done", 32'(n_done - d0), 32'd0);

    // Reset during the high-nibble write of byte 7.
    clear_mem();
    e0 = n_err;
    send(HDR, 2);
    for (int i = 0; i < 7; i++) send(8'(i), 3);
    send(8'h9E, 1);
    rst = 1'b1;
    model_reset(cyc);
    tick(1);
    rst = 1'b0;
    check("rst_busy_next", 32'(busy), 32'd0);
    tick(3);
    check("rst_hi_written", 32'(fbmem[14]), 32'h9);
    check("rst_lo_cancel", 32'(fbwr[15]), 32'd0);
    check("rst_no_err", 32'(n_err - e0), 32'd0);

`ifdef FB_LOADER_CHECKSUM_EN
    // Checksum accept and reject.
    clear_mem();
    d0 = n_done; e0 = n_err;
    send(HDR, 2);
    for (int i = 0; i < NB; i++) send(8'h01, 2);
    send(8'h00, 3);
    tick(3);
    check("csum_ok_done", 32'(n_done - d0), 32'd1);
    send(HDR, 2);
    for (int i = 0; i < NB; i++) send(8'h01, 2);
    send(8'h01, 3);
    tick(3);
    check("csum_bad_err", 32'(n_err - e0), 32'd1);
    check("csum_bad_kept", 32'(fbmem[NPIX-1]), 32'h1);
`endif

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
